// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC snapshot capture sequencer:
// state encodings and default sizing/threshold parameters.
package adc_cap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_FILL   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_PLAY   = 3'd4,
    ST_DONE   = 3'd5
  } cap_state_t;

  localparam int DEF_DEPTH_LOG2  = 13;
  localparam int DEF_ADDR_W      = 14;
  localparam int DEF_QPSK_THRESH = 16300;
  localparam int DEF_SETTLE_CYC  = 16300;

endpackage

// File: rtl/adc_capture_seq_counter.sv
// Loadable, enabled up-counter that saturates at a programmable limit and
// flags when the limit has been reached.
module cap_addr_counter #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  logic [WIDTH-1:0] count_r;

  // Count register: load wins over increment; holds once the limit is hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != limit)) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count    = count_r;
  assign at_limit = (count_r == limit);

endmodule

// File: rtl/adc_capture_seq.sv
// ADC snapshot sequencer: settle after QPSK playback, gate N samples into the
// capture FIFO, drain them into BRAM, then stream BRAM out under ap_ready.
module adc_capture_seq
  import adc_cap_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int QPSK_THRESH = DEF_QPSK_THRESH,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] qpsk_rd_cnt,
  input  logic              adc_valid,
  input  logic              fifo_full,
  input  logic              fifo_almost_full,
  input  logic              fifo_empty,
  output logic              fifo_wr_en,
  output logic              fifo_rd_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic              ap_ready,
  output logic              ap_valid,
  output logic              ap_last,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [2:0]        state
);

  localparam logic [ADDR_W-1:0] ZERO        = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] N_VAL       = ADDR_W'(64'd1 << DEPTH_LOG2);
  localparam logic [ADDR_W-1:0] N_LAST      = ADDR_W'((64'd1 << DEPTH_LOG2) - 64'd1);
  localparam logic [ADDR_W-1:0] SETTLE_V    = ADDR_W'(SETTLE_CYC);
  localparam logic [ADDR_W-1:0] SETTLE_LAST = ADDR_W'(SETTLE_CYC - 1);
  localparam logic [ADDR_W-1:0] QPSK_V      = ADDR_W'(QPSK_THRESH);

  cap_state_t        state_r;
  cap_state_t        next_state_s;
  logic [ADDR_W-1:0] settle_cnt_s;
  logic [ADDR_W-1:0] wr_cnt_s;
  logic [ADDR_W-1:0] rd_cnt_s;
  logic [ADDR_W-1:0] addr_s;
  logic              settle_full_s;
  logic              wr_full_s;
  logic              rd_full_s;
  logic              addr_full_s;
  logic              settle_qual_s;
  logic              settle_go_s;
  logic              settle_en_s;
  logic              wr_ok_s;
  logic              drop_s;
  logic              rd_ok_s;
  logic              addr_en_s;
  logic              addr_clr_s;
  logic              cnt_clr_s;
  logic              play_issue_s;
  logic              fifo_wr_en_r;
  logic              fifo_rd_en_r;
  logic              bram_we_r;
  logic              ap_valid_r;
  logic              ap_last_r;
  logic              busy_r;
  logic              done_r;
  logic              overflow_r;

  cap_addr_counter #(.WIDTH(ADDR_W)) u_settle_cnt (
    .clk(sys_clk), .rst(sys_rst), .load(cnt_clr_s), .load_val(ZERO),
    .en(settle_en_s), .limit(SETTLE_V), .count(settle_cnt_s), .at_limit(settle_full_s)
  );

  cap_addr_counter #(.WIDTH(ADDR_W)) u_wr_cnt (
    .clk(sys_clk), .rst(sys_rst), .load(cnt_clr_s), .load_val(ZERO),
    .en(wr_ok_s), .limit(N_VAL), .count(wr_cnt_s), .at_limit(wr_full_s)
  );

  cap_addr_counter #(.WIDTH(ADDR_W)) u_rd_cnt (
    .clk(sys_clk), .rst(sys_rst), .load(cnt_clr_s), .load_val(ZERO),
    .en(rd_ok_s), .limit(N_VAL), .count(rd_cnt_s), .at_limit(rd_full_s)
  );

  // Shared BRAM address: counts completed writes in DRAIN, issued reads in PLAY.
  cap_addr_counter #(.WIDTH(ADDR_W)) u_addr_cnt (
    .clk(sys_clk), .rst(sys_rst), .load(addr_clr_s), .load_val(ZERO),
    .en(addr_en_s), .limit(N_VAL), .count(addr_s), .at_limit(addr_full_s)
  );

  assign settle_qual_s = (qpsk_rd_cnt >= QPSK_V);
  // The settle count reaching SETTLE_CYC and the move to FILL share one edge.
  assign settle_go_s   = settle_full_s | (settle_qual_s & (settle_cnt_s == SETTLE_LAST));

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and per-cycle counter/strobe control.
  always_comb begin
    next_state_s = state_r;
    settle_en_s  = 1'b0;
    wr_ok_s      = 1'b0;
    drop_s       = 1'b0;
    rd_ok_s      = 1'b0;
    addr_en_s    = 1'b0;
    addr_clr_s   = 1'b0;
    cnt_clr_s    = 1'b0;
    play_issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_SETTLE;
          cnt_clr_s    = 1'b1;
          addr_clr_s   = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        settle_en_s = settle_qual_s;
        if (settle_go_s) begin
          next_state_s = ST_FILL;
        end else begin
          next_state_s = ST_SETTLE;
        end
      end
      ST_FILL: begin
        if (wr_full_s) begin
          next_state_s = ST_DRAIN;
        end else begin
          wr_ok_s = adc_valid & ~fifo_full & ~fifo_almost_full & (wr_cnt_s < N_VAL);
          drop_s  = adc_valid & (fifo_full | fifo_almost_full);
        end
      end
      ST_DRAIN: begin
        rd_ok_s = ~fifo_empty & (rd_cnt_s < N_VAL);
        if (bram_we_r) begin
          if ((addr_s == N_LAST) && rd_full_s) begin
            addr_clr_s   = 1'b1;
            next_state_s = ST_PLAY;
          end else begin
            addr_en_s = 1'b1;
          end
        end else begin
          addr_en_s = 1'b0;
        end
      end
      ST_PLAY: begin
        play_issue_s = ap_ready & ~addr_full_s;
        addr_en_s    = play_issue_s;
        if (ap_last_r) begin
          next_state_s = ST_DONE;
          addr_clr_s   = 1'b1;
        end else begin
          next_state_s = ST_PLAY;
        end
      end
      ST_DONE: begin
        if (start) begin
          next_state_s = ST_FILL;
          cnt_clr_s    = 1'b1;
          addr_clr_s   = 1'b1;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Registered outputs; BRAM write and read-valid trail their issue by one cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fifo_wr_en_r <= 1'b0;
      fifo_rd_en_r <= 1'b0;
      bram_we_r    <= 1'b0;
      ap_valid_r   <= 1'b0;
      ap_last_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      fifo_wr_en_r <= wr_ok_s;
      fifo_rd_en_r <= rd_ok_s;
      bram_we_r    <= fifo_rd_en_r;
      ap_valid_r   <= play_issue_s;
      ap_last_r    <= play_issue_s & (addr_s == N_LAST);
      busy_r       <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
      done_r       <= (state_r == ST_PLAY) && (next_state_s == ST_DONE);
      if (cnt_clr_s) begin
        overflow_r <= 1'b0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign fifo_wr_en = fifo_wr_en_r;
  assign fifo_rd_en = fifo_rd_en_r;
  assign bram_we    = bram_we_r;
  assign bram_addr  = addr_s;
  assign ap_valid   = ap_valid_r;
  assign ap_last    = ap_last_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign overflow   = overflow_r;
  assign state      = state_r;

endmodule

// File: tb/tb_adc_capture_seq.sv
// Directed bench for adc_capture_seq with N=16, SETTLE_CYC=5, QPSK_THRESH=10.
module tb_adc_capture_seq;

  localparam int AW = 5;
  localparam int N  = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] qpsk_rd_cnt = '0;
  logic          adc_valid = 1'b0;
  logic          fifo_full = 1'b0;
  logic          fifo_almost_full = 1'b0;
  logic          fifo_empty = 1'b0;
  logic          ap_ready = 1'b0;
  logic          fifo_wr_en, fifo_rd_en, bram_we, ap_valid, ap_last, busy, done, overflow;
  logic [AW-1:0] bram_addr;
  logic [2:0]    state;

  int errors = 0;
  int checks = 0;

  adc_capture_seq #(.DEPTH_LOG2(4), .ADDR_W(AW), .QPSK_THRESH(10), .SETTLE_CYC(5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .qpsk_rd_cnt(qpsk_rd_cnt),
    .adc_valid(adc_valid), .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .ap_ready(ap_ready), .ap_valid(ap_valid),
    .ap_last(ap_last), .busy(busy), .done(done), .overflow(overflow), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({fifo_wr_en, fifo_rd_en, bram_we, ap_valid, ap_last, busy, done, overflow} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {fifo_wr_en, fifo_rd_en, bram_we, ap_valid, ap_last, busy, done, overflow});
    end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if (bram_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bram_addr); end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_hold: state %0d busy %b want 0 0", state, busy);
    end
  endtask

  task automatic test_settle();
    int left_settle;
    int wr_seen;
    int cyc;
    left_settle = 0; wr_seen = 0; cyc = 0;
    qpsk_rd_cnt = 5'd9; adc_valid = 1'b1; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL settle_entry: state %0d busy %b want 1 1", state, busy);
    end
    repeat (20) begin
      @(negedge sys_clk);
      if (state !== 3'd1) left_settle++;
      if (fifo_wr_en !== 1'b0) wr_seen++;
    end
    checks++;
    if (left_settle != 0) begin
      errors++; $display("FAIL settle_below_thresh: left SETTLE %0d times want 0", left_settle);
    end
    qpsk_rd_cnt = 5'd10;
    while (state !== 3'd2 && cyc < 20) begin
      @(negedge sys_clk);
      cyc++;
      if (fifo_wr_en !== 1'b0) wr_seen++;
    end
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL settle_len: got %0d cycles want 5", cyc); end
    checks++;
    if (wr_seen != 0) begin errors++; $display("FAIL wr_before_fill: got %0d want 0", wr_seen); end
  endtask

  task automatic test_fill(input bit bp);
    int writes;
    int cyc;
    int af_left;
    bit af_done;
    writes = 0; cyc = 0; af_left = 0; af_done = 1'b0;
    adc_valid = 1'b1;
    while (state !== 3'd3 && cyc < 100) begin
      @(negedge sys_clk);
      cyc++;
      if (fifo_wr_en === 1'b1) writes++;
      if (af_left > 0) begin
        af_left--;
        if (af_left == 0) fifo_almost_full = 1'b0;
      end else if (bp && !af_done && writes == 5) begin
        fifo_almost_full = 1'b1; af_left = 3; af_done = 1'b1;
      end
    end
    adc_valid = 1'b0;
    checks++;
    if (writes != N) begin errors++; $display("FAIL fill_writes: got %0d want %0d", writes, N); end
    checks++;
    if (cyc != (bp ? 20 : 17)) begin
      errors++; $display("FAIL fill_len: got %0d want %0d", cyc, bp ? 20 : 17);
    end
    checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL fill_wr_off: got %b want 0", fifo_wr_en); end
    checks++;
    if (overflow !== bp) begin errors++; $display("FAIL fill_overflow: got %b want %b", overflow, bp); end
  endtask

  task automatic test_drain(input bit stall);
    int rd, we, exp_addr, addr_err, follow_err, stall_viol, stall_left, cyc;
    bit stall_done;
    logic prev_rd;
    rd = 0; we = 0; exp_addr = 0; addr_err = 0; follow_err = 0;
    stall_viol = 0; stall_left = 0; cyc = 0; stall_done = 1'b0;
    fifo_empty = 1'b0;
    prev_rd = fifo_rd_en;
    while (state !== 3'd4 && cyc < 100) begin
      @(negedge sys_clk);
      cyc++;
      if (bram_we !== prev_rd) follow_err++;
      if (bram_we === 1'b1) begin
        if (bram_addr !== AW'(exp_addr)) addr_err++;
        exp_addr++; we++;
      end
      if (fifo_rd_en === 1'b1) rd++;
      if (stall_left > 0) begin
        if (fifo_rd_en !== 1'b0) stall_viol++;
        stall_left--;
        if (stall_left == 0) fifo_empty = 1'b0;
      end else if (stall && !stall_done && rd == 6) begin
        fifo_empty = 1'b1; stall_left = 4; stall_done = 1'b1;
      end
      prev_rd = fifo_rd_en;
    end
    checks++;
    if (rd != N) begin errors++; $display("FAIL drain_reads: got %0d want %0d", rd, N); end
    checks++;
    if (we != N) begin errors++; $display("FAIL drain_writes: got %0d want %0d", we, N); end
    checks++;
    if (addr_err != 0) begin errors++; $display("FAIL drain_addr_seq: got %0d bad addrs want 0", addr_err); end
    checks++;
    if (follow_err != 0) begin errors++; $display("FAIL drain_we_lag: got %0d bad cycles want 0", follow_err); end
    if (stall) begin
      checks++;
      if (stall_viol != 0) begin errors++; $display("FAIL drain_stall_rd: got %0d want 0", stall_viol); end
    end
    checks++;
    if (cyc != (stall ? 22 : 18)) begin
      errors++; $display("FAIL drain_len: got %0d want %0d", cyc, stall ? 22 : 18);
    end
    checks++;
    if (bram_addr !== 5'd0 || bram_we !== 1'b0) begin
      errors++; $display("FAIL play_entry: addr %0d we %b want 0 0", bram_addr, bram_we);
    end
  endtask

  task automatic test_play(input bit toggle);
    int issued, valids, lasts, v_err, l_err, cyc, dones, stay_err;
    bit prev_ready, exp_v, exp_l;
    issued = 0; valids = 0; lasts = 0; v_err = 0; l_err = 0; cyc = 0; dones = 0; stay_err = 0;
    ap_ready = 1'b1; prev_ready = 1'b1;
    while (state !== 3'd5 && cyc < 100) begin
      @(negedge sys_clk);
      cyc++;
      exp_v = prev_ready && (issued < N);
      if (exp_v) issued++;
      exp_l = exp_v && (issued == N);
      if (ap_valid !== exp_v) v_err++;
      if (ap_last !== exp_l) l_err++;
      if (ap_valid === 1'b1) valids++;
      if (ap_last === 1'b1) lasts++;
      if (done === 1'b1) dones++;
      ap_ready = toggle ? ~ap_ready : 1'b1;
      prev_ready = ap_ready;
    end
    ap_ready = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      if (done === 1'b1) dones++;
      if (state !== 3'd5 || ap_valid !== 1'b0) stay_err++;
    end
    checks++;
    if (valids != N) begin errors++; $display("FAIL play_valids: got %0d want %0d", valids, N); end
    checks++;
    if (lasts != 1) begin errors++; $display("FAIL play_lasts: got %0d want 1", lasts); end
    checks++;
    if (v_err != 0) begin errors++; $display("FAIL play_valid_timing: got %0d bad cycles want 0", v_err); end
    checks++;
    if (l_err != 0) begin errors++; $display("FAIL play_last_timing: got %0d bad cycles want 0", l_err); end
    checks++;
    if (cyc != (toggle ? 32 : 17)) begin
      errors++; $display("FAIL play_len: got %0d want %0d", cyc, toggle ? 32 : 17);
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL done_pulses: got %0d want 1", dones); end
    checks++;
    if (stay_err != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_hold: bad %0d busy %b want 0 0", stay_err, busy);
    end
  endtask

  task automatic test_rearm();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL rearm_state: got %0d want 2", state); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL rearm_overflow: got %b want 0", overflow); end
    checks++;
    if (bram_addr !== 5'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL rearm_outputs: addr %0d busy %b done %b want 0 1 0", bram_addr, busy, done);
    end
  endtask

  task automatic test_reset_mid_drain();
    test_rearm();
    test_fill(1'b0);
    fifo_empty = 1'b0;
    repeat (6) @(negedge sys_clk);
    checks++;
    if (state !== 3'd3 || fifo_rd_en !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 5'd4) begin
      errors++;
      $display("FAIL pre_reset_drain: state %0d rd %b we %b addr %0d want 3 1 1 4",
               state, fifo_rd_en, bram_we, bram_addr);
    end
    sys_rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL async_reset_state: got %0d want 0", state); end
    checks++;
    if ({fifo_wr_en, fifo_rd_en, bram_we, ap_valid, ap_last, busy, done, overflow} !== 8'h00 ||
        bram_addr !== 5'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b addr %0d want 00000000 0",
               {fifo_wr_en, fifo_rd_en, bram_we, ap_valid, ap_last, busy, done, overflow}, bram_addr);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    qpsk_rd_cnt = 5'd9;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL post_reset_settle: got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_fill(1'b1);
    test_drain(1'b1);
    test_play(1'b1);
    test_rearm();
    test_fill(1'b0);
    test_drain(1'b0);
    test_play(1'b0);
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_seq.md
Name: adc_capture_seq

Overview:
- Single-clock sequencer for the ADC snapshot path: ADC → capture FIFO → snapshot BRAM → amplitude/phase correction.
- Waits for DAC QPSK playback to settle, then gates FIFO writes for exactly 2^DEPTH_LOG2 samples.
- Drains the FIFO into the BRAM with a linear address counter, then streams the BRAM contents out to the correction block under a pull handshake.
- Supports re-arm for repeated captures without a reset.

Parameters:
- DEPTH_LOG2, 13: snapshot length N = 2^DEPTH_LOG2 samples.
- ADDR_W, 14: width of bram_addr and of all count inputs; must be ≥ DEPTH_LOG2+1.
- QPSK_THRESH, 16300: qpsk_rd_cnt level that starts the settle count.
- SETTLE_CYC, 16300: cycles waited after QPSK_THRESH is reached before FILL.

Ports:
- sys_clk  in  1  sole clock.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle arm/re-arm pulse.
- qpsk_rd_cnt  in  ADDR_W  DAC-side QPSK FIFO read count.
- adc_valid  in  1  ADC sample valid.
- fifo_full  in  1  capture FIFO full flag.
- fifo_almost_full  in  1  capture FIFO almost-full flag.
- fifo_empty  in  1  capture FIFO empty flag.
- fifo_wr_en  out  1  capture FIFO write enable.
- fifo_rd_en  out  1  capture FIFO read enable; read data valid 1 cycle later.
- bram_we  out  1  snapshot BRAM write enable.
- bram_addr  out  ADDR_W  snapshot BRAM address, shared by write and read.
- ap_ready  in  1  correction block requests the next sample.
- ap_valid  out  1  BRAM douta holds a valid sample this cycle.
- ap_last  out  1  qualifies the final sample (address N-1).
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  one-cycle pulse on entry to DONE.
- overflow  out  1  sticky: a sample was dropped in FILL; cleared by start.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0, all counters 0.
- All outputs are registered.
- States and encodings: IDLE=0, SETTLE=1, FILL=2, DRAIN=3, PLAY=4, DONE=5.
- IDLE: on start → SETTLE. Clear the settle, write, drain and address counters and overflow.
- SETTLE: the settle counter increments only when qpsk_rd_cnt ≥ QPSK_THRESH. When the count reaches SETTLE_CYC → FILL. Settle is performed only on the first arm after reset.
- FILL:
  - fifo_wr_en(t+1) = adc_valid & ~fifo_full & ~fifo_almost_full & (wr_cnt < N).
  - wr_cnt increments on each asserted fifo_wr_en.
  - adc_valid while full/almost_full → sample dropped, overflow set, wr_cnt not incremented.
  - When wr_cnt reaches N: fifo_wr_en=0 → DRAIN.
- DRAIN:
  - fifo_rd_en = ~fifo_empty & (rd_issued < N).
  - bram_we asserts 1 cycle after each fifo_rd_en, with bram_addr = count of completed writes (0..N-1).
  - bram_addr increments after each write.
  - After the write at N-1: bram_we=0, bram_addr=0 → PLAY.
  - fifo_empty mid-drain stalls without losing addresses.
- PLAY:
  - Each cycle with ap_ready=1 issues a read at bram_addr; the address then increments.
  - ap_valid asserts exactly 1 cycle after each issue (BRAM latency 1).
  - ap_last = ap_valid for address N-1.
  - ap_ready=0 pauses issue. The address never wraps in PLAY.
  - After ap_last is output → DONE.
- DONE: done pulses for one cycle; hold. On start → FILL (re-arm, no settle). Clear counters and overflow; bram_addr=0.
- start outside IDLE/DONE is ignored.
- Reset mid-operation aborts to IDLE immediately. BRAM contents are don't-care.
- Width rule: all counters are ADDR_W bits, unsigned. N must fit, so ADDR_W ≥ DEPTH_LOG2+1.

Decomposition:
- Package adc_cap_pkg: state encodings; defaults for DEPTH_LOG2, ADDR_W, QPSK_THRESH, SETTLE_CYC.
- One natural sub-module: cap_addr_counter, a loadable, enabled, saturating ADDR_W-bit up-counter with terminal flag. Instantiated for settle, write, drain and address counting.

Test Plan (DEPTH_LOG2=4, N=16; SETTLE_CYC=5; QPSK_THRESH=10 unless noted):
- Settle: start; qpsk_rd_cnt=9 for 20 cycles, then 10 → state stays SETTLE during qpsk_rd_cnt=9. FILL entered 5 cycles after qpsk_rd_cnt reaches 10. No fifo_wr_en before FILL.
- Nominal capture: adc_valid=1 continuously, flags 0 → exactly 16 fifo_wr_en cycles. DRAIN writes bram_addr 0..15 with bram_we each 1 cycle after fifo_rd_en. Then PLAY.
- Backpressure: fifo_almost_full=1 for 3 adc_valid cycles mid-FILL → overflow=1. Still 16 writes total. FILL lasts 3 cycles longer.
- Drain stall: fifo_empty=1 for 4 cycles after the 6th read → no fifo_rd_en during the stall. BRAM addresses remain contiguous 0..15.
- Playback handshake: ap_ready toggles 1,0,1,... → ap_valid follows each ap_ready=1 by 1 cycle. 16 valids total, ap_last with the 16th. done pulses once.
- Re-arm and reset: start in DONE → FILL directly, overflow cleared. sys_rst asserted mid-DRAIN → all outputs 0 and state=IDLE in the same cycle.
